// File: rtl/alu_pkg.sv
// alu_pkg: shared state type, default sizes and chunk-count helper for the ALU adders
package alu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;
  function automatic int chunk_count(input int width, input int chunk);
    return width / chunk;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple chain of full-adder cells, also exposing the carry into its MSB
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o,
  output logic             cm_o
);
  logic c;
  // ripple the carry through one full-adder cell per bit; cm_o keeps the carry entering the top cell
  always_comb begin
    c = ci_i;
    cm_o = ci_i;
    s_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cm_o = c;
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end
endmodule

// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: chunk-serial add/subtract with start/busy/done handshake; MULTI_CYCLE_ADDER_OVF_EN adds the V overflow output
module multi_cycle_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Co
`ifdef MULTI_CYCLE_ADDER_OVF_EN
  ,
  output logic             V
`endif
);
  localparam int N = chunk_count(WIDTH, CHUNK);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_t state_q;
  logic [WIDTH-1:0] a_q, b_q, f_q;
  logic [IW-1:0] idx_q;
  logic carry_q, co_q;
  logic [CHUNK-1:0] a_d, b_d, s_d;
  logic cout_d, last_d;
  assign a_d = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_d = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign last_d = idx_q == IW'(N - 1);
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign F = f_q;
  assign Co = co_q;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
  logic cmsb_d, v_q;
  assign V = v_q;
`endif
  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_i (a_d),
    .b_i (b_d),
    .ci_i(carry_q),
    .s_o (s_d),
    .co_o(cout_d),
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    .cm_o(cmsb_d)
`else
    .cm_o()
`endif
  );
  // control FSM: capture operands on an accepted start, one chunk per RUN edge, one-cycle DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      f_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      co_q <= 1'b0;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
      v_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= start ? RUN : IDLE;
          if (start) begin
            a_q <= A;
            b_q <= B ^ {WIDTH{sub}};
            carry_q <= sub | Ci;
            idx_q <= '0;
          end
        end
        RUN: begin
          f_q[int'(idx_q)*CHUNK +: CHUNK] <= s_d;
          carry_q <= cout_d;
          idx_q <= idx_q + 1'b1;
          if (last_d) begin
            state_q <= DONE;
            co_q <= cout_d;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
            v_q <= cmsb_d ^ cout_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb_multi_cycle_adder: table-driven, hand-sequenced and randomized checks of the chunk-serial adder
module tb_multi_cycle_adder;
  logic clk = 1'b0;
  logic rst, start, sub, Ci;
  logic [15:0] A, B;
  logic busy, done, Co;
  logic [15:0] F;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
  logic V;
`endif
  int n_vec = 0;
  int n_err = 0;

  multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .A    (A),
    .B    (B),
    .Ci   (Ci),
    .busy (busy),
    .done (done),
    .F    (F),
    .Co   (Co)
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    ,
    .V    (V)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] f;
    logic        co;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: plain (WIDTH+1)-bit arithmetic; bit 16 is Co, bit 17 the signed overflow
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    logic [15:0] bx;
    logic [16:0] r;
    logic ov;
    bx = sb ? ~b : b;
    r = {1'b0, a} + {1'b0, bx} + {16'd0, sb ? 1'b1 : ci};
    ov = (a[15] == bx[15]) && (r[15] != a[15]);
    return {ov, r};
  endfunction

  // called at posedge+1 after the accepting edge; expects busy for 4 periods then done in period 5
  task automatic wait_done(input string nm, input bit churn);
    int k;
    for (k = 1; k <= 20; k++) begin
      if (done) break;
      chk({nm, " busy"}, {31'd0, busy}, 32'd1);
      if (churn) begin
        @(negedge clk);
        A = 16'($urandom);
        B = 16'($urandom);
      end
      @(posedge clk);
      #1;
    end
    chk({nm, " latency"}, k, 32'd5);
    chk({nm, " busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb, input string nm);
    @(negedge clk);
    A = a;
    B = b;
    Ci = ci;
    sub = sb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    Ci = 1'($urandom);
    sub = 1'($urandom);
    wait_done(nm, 1'b0);
  endtask

  initial begin
    logic [17:0] r;
    logic [15:0] ra, rb;
    logic rci, rsb;
    int seen;
    tv[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    tv[2] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1};
    tv[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0};
    tv[4] = '{16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1};
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    Ci = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset F", {16'd0, F}, 32'd0);
    chk("reset Co", {31'd0, Co}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].ci, tv[i].sb, $sformatf("tv%0d", i));
      chk($sformatf("tv%0d F", i), {16'd0, F}, {16'd0, tv[i].f});
      chk($sformatf("tv%0d Co", i), {31'd0, Co}, {31'd0, tv[i].co});
    end

    @(negedge clk);
    A = 16'h1111;
    B = 16'h2222;
    Ci = 1'b0;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("hold", 1'b1);
    chk("hold F", {16'd0, F}, 32'h3333);
    chk("hold Co", {31'd0, Co}, 32'd0);
    @(negedge clk);
    A = 16'h0001;
    B = 16'h0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("b2b", 1'b0);
    chk("b2b F", {16'd0, F}, 32'h0002);
    chk("b2b Co", {31'd0, Co}, 32'd0);

    @(negedge clk);
    A = 16'h1234;
    B = 16'h0FCD;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst F", {16'd0, F}, 32'd0);
    chk("midrst Co", {31'd0, Co}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("midrst no_done", seen, 32'd0);
    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, "postrst");
    chk("postrst F", {16'd0, F}, 32'h2201);
    chk("postrst Co", {31'd0, Co}, 32'd0);

`ifdef MULTI_CYCLE_ADDER_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf1");
    chk("ovf1 F", {16'd0, F}, 32'h8000);
    chk("ovf1 V", {31'd0, V}, 32'd1);
    chk("ovf1 Co", {31'd0, Co}, 32'd0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ovf2");
    chk("ovf2 V", {31'd0, V}, 32'd0);
    chk("ovf2 Co", {31'd0, Co}, 32'd1);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rci = 1'($urandom);
      rsb = 1'($urandom);
      r = model(ra, rb, rci, rsb);
      run_op(ra, rb, rci, rsb, $sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d F", i), {16'd0, F}, {16'd0, r[15:0]});
      chk($sformatf("rnd%0d Co", i), {31'd0, Co}, {31'd0, r[16]});
`ifdef MULTI_CYCLE_ADDER_OVF_EN
      chk($sformatf("rnd%0d V", i), {31'd0, V}, {31'd0, r[17]});
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multi_cycle_adder.md
Name: multi_cycle_adder

Overview:
- Parametrised multi-cycle adder/subtractor, WIDTH bits wide.
- Processes CHUNK bits per clock through a ripple chain of full-adder cells, with the carry held in a register between chunks.
- Successor to the 1-bit full-adder cell: adds width generalisation, a subtract mode and a start/busy/done handshake.
- Sits in the ALU datapath as the area-cheap adder for the experiment CPU.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- sub  input  1  0 = A+B+Ci; 1 = A-B (computed as A+~B+1; Ci ignored).
- A  input  WIDTH  operand A, captured on the accepted start.
- B  input  WIDTH  operand B, captured on the accepted start.
- Ci  input  1  carry-in, captured on the accepted start.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse when F/Co become valid.
- F  output  WIDTH  result.
- Co  output  1  carry-out of the MSB; for sub, 1 = no borrow.

Behaviour:
Fixed by the interface:
- One clock. Reset is asynchronous and active-high.

Reset:
- Asserting rst forces state=IDLE and clears busy, done, F, Co and all internal registers to 0 immediately.
- This applies mid-operation too: the operation in flight is abandoned and no done is produced.

States and transitions:
- IDLE -> RUN on a rising edge with start=1. That edge latches A, B^{WIDTH{sub}}, and carry = sub ? 1 : Ci. It also clears the chunk index to 0.
- RUN: each edge computes chunk idx (bits idx*CHUNK +: CHUNK) as a + b + carry.
  - The sum is written into F at that slice.
  - carry is updated with the chunk carry-out.
  - idx increments.
  - After N = WIDTH/CHUNK RUN edges: Co <= final carry, then go to DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE.
  - start=1 in the DONE cycle is accepted: go directly to RUN (back-to-back operation).

Handshake and timing:
- busy=1 in RUN only.
- start is ignored while busy=1. Inputs A/B/Ci/sub may change freely after acceptance.
- Latency: start sampled at edge 0 -> done high in cycle N+1.
  - Default configuration (N=4): done high in cycle 5.
- F/Co keep their last result until the next accepted start. F is not cleared on start; partial updates are visible during RUN.

Arithmetic and width rules:
- Arithmetic is modulo 2^WIDTH.
- idx width is clog2(N), with a minimum of 1.
- CHUNK == WIDTH is legal: N=1, single RUN cycle.

Optional Feature:
- MULTI_CYCLE_ADDER_OVF_EN defined:
  - Adds output port V (1 bit): signed overflow, equal to the carry into the MSB XOR the carry out of the MSB.
  - V is registered alongside Co, reset to 0, and valid when done=1.
- Not defined:
  - No V port and no overflow logic.
  - All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - state typedef {IDLE, RUN, DONE}
  - default WIDTH/CHUNK constants
  - a chunk-count function
- One sub-module: chunk_adder (parameter CHUNK). It is a combinational CHUNK-bit ripple chain of full-adder cells with carry in/out, and also exposes the carry into its MSB for V.
- multi_cycle_adder instantiates chunk_adder once and muxes the operand slices by idx.

Test Plan (WIDTH=16, CHUNK=4):
- A=0x1234, B=0x0FCD, Ci=0, sub=0, start pulse at cycle 0 -> busy in cycles 1-4, done in cycle 5, F=0x2201, Co=0.
- A=0xFFFF, B=0x0001, Ci=0 -> F=0x0000, Co=1. With Ci=1 instead -> F=0x0001, Co=1.
- sub=1, A=0x0005, B=0x0007, Ci=1 -> F=0xFFFE, Co=0 (borrow; Ci ignored). Then A=0x0009, B=0x0003 -> F=0x0006, Co=1.
- start held high through RUN with changing A/B -> result reflects the first capture only. start in the DONE cycle with A=0x0001, B=0x0001 -> busy in the next cycle, second done 5 cycles after the first, F=0x0002.
- rst asserted mid-RUN (cycle 2) -> busy, done, F and Co are 0 asynchronously. No done follows. A new start after reset works normally.
- With MULTI_CYCLE_ADDER_OVF_EN: 0x7FFF+0x0001 -> F=0x8000, V=1, Co=0; 0xFFFF+0x0001 -> V=0, Co=1.
